reg_bank: RTL and testbench

// - Parametrised multi-entry operand register bank for the ALU datapath; generalises the single 4-bit load/clear register.
// - DEPTH entries of WIDTH bits, one write port with per-cycle op (load/clear/shift/inc/dec), two registered read ports.
// - Sits between switch/operand capture logic and the ALU core; also holds results written back from the ALU.

---
 rtl/alu_pkg.sv | 16 +
 rtl/reg_bank_alu_op.sv | 47 ++++
 rtl/reg_bank.sv | 102 ++++++++++
 tb/tb_reg_bank.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: write-op encodings and default data width.
package alu_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned OP_W      = 3;

    localparam logic [OP_W-1:0] OP_HOLD = 3'b000;
    localparam logic [OP_W-1:0] OP_LOAD = 3'b001;
    localparam logic [OP_W-1:0] OP_CLR  = 3'b010;
    localparam logic [OP_W-1:0] OP_SHL  = 3'b011;
    localparam logic [OP_W-1:0] OP_SHR  = 3'b100;
    localparam logic [OP_W-1:0] OP_INC  = 3'b101;
    localparam logic [OP_W-1:0] OP_DEC  = 3'b110;
    localparam logic [OP_W-1:0] OP_RSVD = 3'b111;

endpackage

// File: rtl/reg_bank_alu_op.sv
// Combinational next-value and carry for one register-bank entry under a write op.
module reg_bank_alu_op
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] cur,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] nxt_c,
    output logic             carry_c,
    output logic             carry_en_c
);

    // Decode op; only shift and inc/dec touch the carry flag, everything else holds it.
    always_comb begin
        nxt_c      = cur;
        carry_c    = 1'b0;
        carry_en_c = 1'b0;
        case (op)
            OP_LOAD: nxt_c = din;
            OP_CLR:  nxt_c = '0;
            OP_SHL: begin
                nxt_c      = {cur[WIDTH-2:0], din[0]};
                carry_c    = cur[WIDTH-1];
                carry_en_c = 1'b1;
            end
            OP_SHR: begin
                nxt_c      = {din[0], cur[WIDTH-1:1]};
                carry_c    = cur[0];
                carry_en_c = 1'b1;
            end
            OP_INC: begin
                nxt_c      = cur + WIDTH'(1);
                carry_c    = &cur;
                carry_en_c = 1'b1;
            end
            OP_DEC: begin
                nxt_c      = cur - WIDTH'(1);
                carry_c    = ~|cur;
                carry_en_c = 1'b1;
            end
            default: nxt_c = cur;
        endcase
    end

endmodule

// File: rtl/reg_bank.sv
// Operand register bank: one write port with in-place ALU ops, two registered
// read ports with write-first bypass, registered carry flag.
module reg_bank
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             sclr,
    input  logic             we,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] D_in,
    input  logic             re,
    input  logic [AW-1:0]    raddr_a,
    input  logic [AW-1:0]    raddr_b,
    output logic [WIDTH-1:0] D_out_a,
    output logic [WIDTH-1:0] D_out_b,
    output logic             rvalid,
    output logic             carry_out
);

    logic [WIDTH-1:0] mem [DEPTH];

    logic             waddr_ok_c;
    logic             wr_hit_c;
    logic [WIDTH-1:0] cur_c;
    logic [WIDTH-1:0] nxt_c;
    logic             carry_c;
    logic             carry_en_c;
    logic [WIDTH-1:0] rd_a_c;
    logic [WIDTH-1:0] rd_b_c;

    // Write-port qualification; an out-of-range index suppresses the write entirely.
    always_comb begin
        waddr_ok_c = 32'(waddr) < DEPTH;
        wr_hit_c   = we && waddr_ok_c && !sclr;
        cur_c      = waddr_ok_c ? mem[waddr] : '0;
    end

    reg_bank_alu_op #(
        .WIDTH (WIDTH)
    ) u_alu_op (
        .op         (op),
        .cur        (cur_c),
        .din        (D_in),
        .nxt_c      (nxt_c),
        .carry_c    (carry_c),
        .carry_en_c (carry_en_c)
    );

    // Read muxes: out-of-range reads 0, same-index write returns the post-op value.
    always_comb begin
        rd_a_c = '0;
        rd_b_c = '0;
        if (32'(raddr_a) < DEPTH) begin
            rd_a_c = (wr_hit_c && raddr_a == waddr) ? nxt_c : mem[raddr_a];
        end
        if (32'(raddr_b) < DEPTH) begin
            rd_b_c = (wr_hit_c && raddr_b == waddr) ? nxt_c : mem[raddr_b];
        end
    end

    // Storage and carry flag: async reset, then sync clear, then the write op.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            carry_out <= 1'b0;
        end else if (sclr) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            carry_out <= 1'b0;
        end else if (wr_hit_c) begin
            mem[waddr] <= nxt_c;
            if (carry_en_c) begin
                carry_out <= carry_c;
            end
        end
    end

    // Registered read ports; data holds when no read is issued.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            D_out_a <= '0;
            D_out_b <= '0;
            rvalid  <= 1'b0;
        end else begin
            rvalid <= re;
            if (re) begin
                D_out_a <= sclr ? '0 : rd_a_c;
                D_out_b <= sclr ? '0 : rd_b_c;
            end
        end
    end

endmodule

// File: tb/tb_reg_bank.sv
// Directed bench for reg_bank: a DEPTH=4 instance plus a DEPTH=3 instance sharing stimulus.
module tb_reg_bank;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       sclr;
    logic       we;
    logic [2:0] op;
    logic [1:0] waddr;
    logic [3:0] D_in;
    logic       re;
    logic [1:0] raddr_a;
    logic [1:0] raddr_b;

    logic [3:0] D_out_a, D_out_b;
    logic       rvalid, carry_out;
    logic [3:0] d3_a, d3_b;
    logic       d3_rvalid, d3_carry;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    reg_bank #(.WIDTH(4), .DEPTH(4)) dut (
        .clk(clk), .clr_n(clr_n), .sclr(sclr), .we(we), .op(op), .waddr(waddr),
        .D_in(D_in), .re(re), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .D_out_a(D_out_a), .D_out_b(D_out_b), .rvalid(rvalid), .carry_out(carry_out)
    );

    reg_bank #(.WIDTH(4), .DEPTH(3)) dut3 (
        .clk(clk), .clr_n(clr_n), .sclr(sclr), .we(we), .op(op), .waddr(waddr),
        .D_in(D_in), .re(re), .raddr_a(raddr_a), .raddr_b(raddr_b),
        .D_out_a(d3_a), .D_out_b(d3_b), .rvalid(d3_rvalid), .carry_out(d3_carry)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [2:0] o, input logic [1:0] a, input logic [3:0] d);
        we = 1'b1; op = o; waddr = a; D_in = d;
        tick();
        we = 1'b0; op = OP_HOLD; D_in = 4'h0;
    endtask

    task automatic do_read(input logic [1:0] a, input logic [1:0] b);
        re = 1'b1; raddr_a = a; raddr_b = b;
        tick();
        re = 1'b0;
    endtask

    task automatic test_reset();
        clr_n = 1'b0; sclr = 1'b0; we = 1'b0; op = OP_HOLD; waddr = '0; D_in = '0;
        re = 1'b0; raddr_a = '0; raddr_b = '0;
        repeat (2) tick();
        n_checks++; if (D_out_a !== 4'h0) begin n_fail++; $display("FAIL reset_a: got %h expected 0", D_out_a); end
        n_checks++; if (D_out_b !== 4'h0) begin n_fail++; $display("FAIL reset_b: got %h expected 0", D_out_b); end
        n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b expected 0", rvalid); end
        n_checks++; if (carry_out !== 1'b0) begin n_fail++; $display("FAIL reset_carry: got %b expected 0", carry_out); end
        clr_n = 1'b1;
        tick();
    endtask

    task automatic test_load_read();
        do_write(OP_LOAD, 2'd2, 4'hA);
        do_read(2'd2, 2'd0);
        n_checks++; if (D_out_a !== 4'hA) begin n_fail++; $display("FAIL load_a: got %h expected a", D_out_a); end
        n_checks++; if (D_out_b !== 4'h0) begin n_fail++; $display("FAIL load_b: got %h expected 0", D_out_b); end
        n_checks++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL load_rvalid: got %b expected 1", rvalid); end
        tick();
        n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL idle_rvalid: got %b expected 0", rvalid); end
        n_checks++; if (D_out_a !== 4'hA) begin n_fail++; $display("FAIL idle_hold_a: got %h expected a", D_out_a); end
    endtask

    task automatic test_inc_dec();
        do_write(OP_LOAD, 2'd1, 4'hF);
        do_write(OP_INC, 2'd1, 4'h0);
        n_checks++; if (carry_out !== 1'b1) begin n_fail++; $display("FAIL inc_wrap_carry: got %b expected 1", carry_out); end
        do_read(2'd1, 2'd1);
        n_checks++; if (D_out_a !== 4'h0) begin n_fail++; $display("FAIL inc_wrap_val: got %h expected 0", D_out_a); end
        do_write(OP_DEC, 2'd1, 4'h0);
        n_checks++; if (carry_out !== 1'b1) begin n_fail++; $display("FAIL dec_wrap_carry: got %b expected 1", carry_out); end
        do_read(2'd1, 2'd0);
        n_checks++; if (D_out_a !== 4'hF) begin n_fail++; $display("FAIL dec_wrap_val: got %h expected f", D_out_a); end
        do_write(OP_LOAD, 2'd1, 4'h3);
        n_checks++; if (carry_out !== 1'b1) begin n_fail++; $display("FAIL load_keeps_carry: got %b expected 1", carry_out); end
        do_write(OP_INC, 2'd1, 4'h0);
        n_checks++; if (carry_out !== 1'b0) begin n_fail++; $display("FAIL inc_carry: got %b expected 0", carry_out); end
        do_read(2'd1, 2'd1);
        n_checks++; if (D_out_b !== 4'h4) begin n_fail++; $display("FAIL inc_val: got %h expected 4", D_out_b); end
    endtask

    task automatic test_shift();
        do_write(OP_LOAD, 2'd0, 4'b1001);
        do_write(OP_SHL, 2'd0, 4'b0001);
        n_checks++; if (carry_out !== 1'b1) begin n_fail++; $display("FAIL shl_carry: got %b expected 1", carry_out); end
        do_read(2'd0, 2'd0);
        n_checks++; if (D_out_a !== 4'b0011) begin n_fail++; $display("FAIL shl_val: got %b expected 0011", D_out_a); end
        do_write(OP_SHR, 2'd0, 4'b0000);
        n_checks++; if (carry_out !== 1'b1) begin n_fail++; $display("FAIL shr_carry: got %b expected 1", carry_out); end
        do_read(2'd0, 2'd0);
        n_checks++; if (D_out_a !== 4'b0001) begin n_fail++; $display("FAIL shr_val: got %b expected 0001", D_out_a); end
        do_write(OP_SHL, 2'd0, 4'b1110);
        n_checks++; if (carry_out !== 1'b0) begin n_fail++; $display("FAIL shl0_carry: got %b expected 0", carry_out); end
        do_read(2'd0, 2'd0);
        n_checks++; if (D_out_a !== 4'b0010) begin n_fail++; $display("FAIL shl0_val: got %b expected 0010", D_out_a); end
    endtask

    task automatic test_bypass();
        we = 1'b1; op = OP_LOAD; waddr = 2'd3; D_in = 4'h5;
        re = 1'b1; raddr_a = 2'd3; raddr_b = 2'd3;
        tick();
        we = 1'b0; re = 1'b0;
        n_checks++; if (D_out_a !== 4'h5) begin n_fail++; $display("FAIL bypass_a: got %h expected 5", D_out_a); end
        n_checks++; if (D_out_b !== 4'h5) begin n_fail++; $display("FAIL bypass_b: got %h expected 5", D_out_b); end
        we = 1'b1; op = OP_INC; waddr = 2'd3; D_in = 4'h0;
        re = 1'b1; raddr_a = 2'd3; raddr_b = 2'd2;
        tick();
        we = 1'b0; re = 1'b0; op = OP_HOLD;
        n_checks++; if (D_out_a !== 4'h6) begin n_fail++; $display("FAIL bypass_inc_a: got %h expected 6", D_out_a); end
        n_checks++; if (D_out_b !== 4'hA) begin n_fail++; $display("FAIL bypass_other_b: got %h expected a", D_out_b); end
    endtask

    task automatic test_sclr();
        do_write(OP_LOAD, 2'd2, 4'hF);
        do_write(OP_INC, 2'd2, 4'h0);
        n_checks++; if (carry_out !== 1'b1) begin n_fail++; $display("FAIL pre_sclr_carry: got %b expected 1", carry_out); end
        sclr = 1'b1; we = 1'b1; op = OP_LOAD; waddr = 2'd0; D_in = 4'h7;
        re = 1'b1; raddr_a = 2'd0; raddr_b = 2'd3;
        tick();
        sclr = 1'b0; we = 1'b0; re = 1'b0; op = OP_HOLD;
        n_checks++; if (D_out_a !== 4'h0) begin n_fail++; $display("FAIL sclr_read_a: got %h expected 0", D_out_a); end
        n_checks++; if (D_out_b !== 4'h0) begin n_fail++; $display("FAIL sclr_read_b: got %h expected 0", D_out_b); end
        n_checks++; if (rvalid !== 1'b1) begin n_fail++; $display("FAIL sclr_rvalid: got %b expected 1", rvalid); end
        n_checks++; if (carry_out !== 1'b0) begin n_fail++; $display("FAIL sclr_carry: got %b expected 0", carry_out); end
        do_read(2'd0, 2'd3);
        n_checks++; if (D_out_a !== 4'h0) begin n_fail++; $display("FAIL sclr_e0: got %h expected 0", D_out_a); end
        n_checks++; if (D_out_b !== 4'h0) begin n_fail++; $display("FAIL sclr_e3: got %h expected 0", D_out_b); end
        do_read(2'd1, 2'd2);
        n_checks++; if (D_out_a !== 4'h0) begin n_fail++; $display("FAIL sclr_e1: got %h expected 0", D_out_a); end
    endtask

    task automatic test_range();
        do_write(OP_LOAD, 2'd2, 4'hF);
        do_write(OP_INC, 2'd2, 4'h0);
        do_write(OP_INC, 2'd3, 4'h0);
        n_checks++; if (carry_out !== 1'b0) begin n_fail++; $display("FAIL range_d4_carry: got %b expected 0", carry_out); end
        n_checks++; if (d3_carry !== 1'b1) begin n_fail++; $display("FAIL range_d3_carry_hold: got %b expected 1", d3_carry); end
        do_write(OP_LOAD, 2'd3, 4'h9);
        do_read(2'd3, 2'd2);
        n_checks++; if (D_out_a !== 4'h9) begin n_fail++; $display("FAIL range_d4_e3: got %h expected 9", D_out_a); end
        n_checks++; if (d3_a !== 4'h0) begin n_fail++; $display("FAIL range_d3_oob_read: got %h expected 0", d3_a); end
        n_checks++; if (d3_rvalid !== 1'b1) begin n_fail++; $display("FAIL range_d3_rvalid: got %b expected 1", d3_rvalid); end
        we = 1'b1; op = OP_LOAD; waddr = 2'd3; D_in = 4'hC;
        re = 1'b1; raddr_a = 2'd3; raddr_b = 2'd1;
        tick();
        we = 1'b0; re = 1'b0; op = OP_HOLD;
        n_checks++; if (D_out_a !== 4'hC) begin n_fail++; $display("FAIL range_d4_bypass: got %h expected c", D_out_a); end
        n_checks++; if (d3_a !== 4'h0) begin n_fail++; $display("FAIL range_d3_oob_bypass: got %h expected 0", d3_a); end
    endtask

    task automatic test_reset_mid();
        do_write(OP_LOAD, 2'd0, 4'h5);
        do_write(OP_DEC, 2'd2, 4'h0);
        do_read(2'd0, 2'd2);
        n_checks++; if (D_out_a !== 4'h5) begin n_fail++; $display("FAIL pre_rst_a: got %h expected 5", D_out_a); end
        n_checks++; if (carry_out !== 1'b1) begin n_fail++; $display("FAIL pre_rst_carry: got %b expected 1", carry_out); end
        we = 1'b1; op = OP_LOAD; waddr = 2'd1; D_in = 4'hE;
        re = 1'b1; raddr_a = 2'd0; raddr_b = 2'd2;
        #3;
        clr_n = 1'b0;
        #1;
        n_checks++; if (D_out_a !== 4'h0) begin n_fail++; $display("FAIL async_rst_a: got %h expected 0", D_out_a); end
        n_checks++; if (D_out_b !== 4'h0) begin n_fail++; $display("FAIL async_rst_b: got %h expected 0", D_out_b); end
        n_checks++; if (rvalid !== 1'b0) begin n_fail++; $display("FAIL async_rst_rvalid: got %b expected 0", rvalid); end
        n_checks++; if (carry_out !== 1'b0) begin n_fail++; $display("FAIL async_rst_carry: got %b expected 0", carry_out); end
        tick();
        clr_n = 1'b1; we = 1'b0; re = 1'b0; op = OP_HOLD;
        tick();
        do_read(2'd0, 2'd1);
        n_checks++; if (D_out_a !== 4'h0) begin n_fail++; $display("FAIL post_rst_e0: got %h expected 0", D_out_a); end
        n_checks++; if (D_out_b !== 4'h0) begin n_fail++; $display("FAIL post_rst_e1: got %h expected 0", D_out_b); end
    endtask

    initial begin
        test_reset();
        test_load_read();
        test_inc_dec();
        test_shift();
        test_bypass();
        test_sclr();
        test_range();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
